// File: rtl/serial_to_parallel.sv
// Serial-in, parallel-out shift register: one enabled bit per clock enters at
// DATA[0]; the oldest bit falls off DATA[DEPTH-1].
module serial_to_parallel #(
    parameter int DEPTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             DATA_IN,
    input  logic             EN,
    output logic [DEPTH-1:0] DATA
);

    logic [DEPTH-1:0] shift_q;

    // A single-bit register has no shift path; keep the slice out of that build.
    generate
        if (DEPTH == 1) begin : g_single
            always_ff @(posedge CLK or posedge RST) begin
                if (RST) begin
                    shift_q <= '0;
                end else if (EN) begin
                    shift_q[0] <= DATA_IN;
                end
            end
        end else begin : g_shift
            always_ff @(posedge CLK or posedge RST) begin
                if (RST) begin
                    shift_q <= '0;
                end else if (EN) begin
                    shift_q <= {shift_q[DEPTH-2:0], DATA_IN};
                end
            end
        end
    endgenerate

    assign DATA = shift_q;

endmodule

// File: tb/tb_serial_to_parallel.sv
// Directed bench for serial_to_parallel at DEPTH 3, 1 and 8 sharing one
// stimulus stream; expected words are hand-computed.
module tb_serial_to_parallel;

    logic       CLK;
    logic       RST;
    logic       DATA_IN;
    logic       EN;
    logic [2:0] data3;
    logic [0:0] data1;
    logic [7:0] data8;

    int errors = 0;
    int checks = 0;

    logic [2:0] exp_q[$];

    serial_to_parallel #(.DEPTH(3)) dut3 (
        .CLK(CLK), .RST(RST), .DATA_IN(DATA_IN), .EN(EN), .DATA(data3)
    );
    serial_to_parallel #(.DEPTH(1)) dut1 (
        .CLK(CLK), .RST(RST), .DATA_IN(DATA_IN), .EN(EN), .DATA(data1)
    );
    serial_to_parallel #(.DEPTH(8)) dut8 (
        .CLK(CLK), .RST(RST), .DATA_IN(DATA_IN), .EN(EN), .DATA(data8)
    );

    // Clock and reset
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle away from it.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Shift one bit through the DEPTH=3 instance and compare against the next queued word.
    task automatic shift3(input logic bit_in, input string tag);
        logic [2:0] exp;
        EN      = 1'b1;
        DATA_IN = bit_in;
        tick();
        exp = exp_q.pop_front();
        check(tag, {29'd0, data3}, {29'd0, exp});
    endtask

    logic [8:0] seq_bits;
    logic [2:0] seq_exp3 [9];
    logic [7:0] seq_exp8 [9];

    initial begin
        seq_bits = 9'b1_0100_1101;  // LSB first: 1,0,1,1,0,0,1,0,1
        seq_exp3 = '{3'b001, 3'b010, 3'b101, 3'b011, 3'b110, 3'b100, 3'b001, 3'b010, 3'b101};
        seq_exp8 = '{8'h01, 8'h02, 8'h05, 8'h0B, 8'h16, 8'h2C, 8'h59, 8'hB2, 8'h65};

        // Reset with no clock edge yet
        RST     = 1'b1;
        EN      = 1'b0;
        DATA_IN = 1'b0;
        #1;
        check("reset_no_clk_d3", {29'd0, data3}, 32'd0);
        check("reset_no_clk_d1", {31'd0, data1}, 32'd0);
        check("reset_no_clk_d8", {24'd0, data8}, 32'd0);

        // Reset held across enabled edges
        EN      = 1'b1;
        DATA_IN = 1'b1;
        tick();
        tick();
        check("reset_held_d3", {29'd0, data3}, 32'd0);

        // Release, disabled edge
        RST     = 1'b0;
        EN      = 1'b0;
        DATA_IN = 1'b1;
        tick();
        check("en_low_hold_d3", {29'd0, data3}, 32'd0);
        check("en_low_hold_d8", {24'd0, data8}, 32'd0);

        exp_q.push_back(3'b001);
        exp_q.push_back(3'b010);
        exp_q.push_back(3'b101);
        shift3(1'b1, "shift_1");
        shift3(1'b0, "shift_10");
        shift3(1'b1, "shift_101");

        // Hold with EN low; toggle EN between edges to show it has no effect
        EN      = 1'b0;
        DATA_IN = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #2 EN = 1'b1;
            #1 EN = 1'b0;
            tick();
            check("hold_101", {29'd0, data3}, 32'b101);
        end

        // Asynchronous reset mid-cycle
        #2 RST = 1'b1;
        #1;
        check("async_rst_d3", {29'd0, data3}, 32'd0);
        check("async_rst_d8", {24'd0, data8}, 32'd0);
        @(negedge CLK);
        RST = 1'b0;

        exp_q.push_back(3'b001);
        exp_q.push_back(3'b011);
        exp_q.push_back(3'b111);
        exp_q.push_back(3'b110);
        shift3(1'b1, "ovf_1");
        shift3(1'b1, "ovf_11");
        shift3(1'b1, "ovf_111");
        shift3(1'b0, "ovf_110");
        check("ovf_d1", {31'd0, data1}, 32'd0);
        check("ovf_d8", {24'd0, data8}, 32'h0E);

        // Reset coincident with an enabled rising edge
        EN      = 1'b1;
        DATA_IN = 1'b1;
        @(posedge CLK);
        RST = 1'b1;
        #1;
        check("rst_at_edge_d3", {29'd0, data3}, 32'd0);
        check("rst_at_edge_d8", {24'd0, data8}, 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        tick();
        check("post_rst_d3", {29'd0, data3}, 32'b001);
        check("post_rst_d1", {31'd0, data1}, 32'd1);
        check("post_rst_d8", {24'd0, data8}, 32'h01);

        // Fresh run across all three depths
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        for (int i = 0; i < 9; i++) begin
            EN      = 1'b1;
            DATA_IN = seq_bits[i];
            tick();
            check($sformatf("seq_d3_%0d", i), {29'd0, data3}, {29'd0, seq_exp3[i]});
            check($sformatf("seq_d1_%0d", i), {31'd0, data1}, {31'd0, seq_bits[i]});
            check($sformatf("seq_d8_%0d", i), {24'd0, data8}, {24'd0, seq_exp8[i]});
        end

        // Gap in EN pauses; assembly resumes afterwards
        EN      = 1'b0;
        DATA_IN = 1'b0;
        tick();
        tick();
        check("gap_d8", {24'd0, data8}, 32'h65);
        check("gap_d1", {31'd0, data1}, 32'd1);
        EN = 1'b1;
        tick();
        check("resume_d8", {24'd0, data8}, 32'hCA);
        check("resume_d1", {31'd0, data1}, 32'd0);
        check("resume_d3", {29'd0, data3}, 32'b010);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
